// File: rtl/ecc_pkg.sv
// Shared codes for the ECC decode path: cfg width codes, NOF codes, status codes,
// controller state encoding and the latched syndrome result.
package ecc_pkg;

    localparam logic [1:0] CW_SMALL  = 2'b00;
    localparam logic [1:0] CW_MEDIUM = 2'b01;
    localparam logic [1:0] CW_LARGE  = 2'b10;

    localparam logic [1:0] NOF_NONE  = 2'b00;
    localparam logic [1:0] NOF_ONE   = 2'b01;
    localparam logic [1:0] NOF_MULTI = 2'b10;

    localparam logic [1:0] ST_CLEAN  = 2'b00;
    localparam logic [1:0] ST_CORR   = 2'b01;
    localparam logic [1:0] ST_UNCORR = 2'b10;
    localparam logic [1:0] ST_TMO    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SYND = 3'd1,
        S_FIX  = 3'd2,
        S_CAPT = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    typedef struct packed {
        logic [4:0] s;
        logic [1:0] nof;
    } synd_res_t;

endpackage

// File: rtl/ecc_stat_cnt.sv
// Saturating event counter; synchronous clear has priority over increment.
module ecc_stat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != '1))
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/ecc_dec_ctrl.sv
// ECC decode sequencer: IDLE->SYND->FIX->CAPT->OUT, one codeword in flight.
// Optional statistics counters are built when ECC_STATS_EN is defined.
module ecc_dec_ctrl
    import ecc_pkg::*;
#(
    parameter int AMBA_WORD = 32,
    parameter int TIMEOUT   = 15,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef ECC_STATS_EN
    input  logic                 stat_clr,
    output logic [CNT_WIDTH-1:0] cnt_corr,
    output logic [CNT_WIDTH-1:0] cnt_uncorr,
    output logic [CNT_WIDTH-1:0] cnt_tmo,
`endif
    input  logic [1:0]           cfg_width,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AMBA_WORD-1:0] in_data,
    output logic                 synd_start,
    output logic [AMBA_WORD-1:0] synd_data,
    input  logic                 synd_done,
    input  logic [4:0]           synd_s,
    input  logic [1:0]           synd_nof,
    output logic [4:0]           fix_s,
    output logic [1:0]           fix_nof,
    output logic                 fix_small,
    output logic                 fix_medium,
    output logic [AMBA_WORD-1:0] fix_data,
    input  logic [AMBA_WORD-1:0] fix_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AMBA_WORD-1:0] out_data,
    output logic [1:0]           out_nof,
    output logic                 busy
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t              state, state_n;
    logic [AMBA_WORD-1:0] word_q;
    logic [1:0]           cfg_q;
    synd_res_t            res_q;
    logic [TW-1:0]        tmo_cnt;
    logic                 first_synd;
    logic                 tmo_hit;

    // tmo_cnt restarts at 0 on accept, so 0 marks the first SYND cycle
    assign first_synd = (tmo_cnt == '0);
    assign tmo_hit    = (tmo_cnt == TW'(TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (in_valid) state_n = S_SYND;
            S_SYND: begin
                if (synd_done && !first_synd)
                    state_n = S_FIX;
                else if (tmo_hit)
                    state_n = S_OUT;
            end
            S_FIX:  state_n = S_CAPT;
            S_CAPT: state_n = S_OUT;
            S_OUT:  if (out_ready) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (state == S_IDLE);
        busy       = (state != S_IDLE);
        synd_start = (state == S_SYND) && first_synd;
        out_valid  = (state == S_OUT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q   <= '0;
            cfg_q    <= '0;
            res_q    <= '0;
            tmo_cnt  <= '0;
            out_data <= '0;
            out_nof  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        word_q  <= in_data;
                        cfg_q   <= cfg_width;
                        tmo_cnt <= '0;
                    end
                end
                S_SYND: begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                    if (synd_done && !first_synd) begin
                        res_q <= '{s: synd_s, nof: synd_nof};
                    end else if (tmo_hit) begin
                        out_data <= word_q;
                        out_nof  <= ST_TMO;
                    end
                end
                S_CAPT: begin
                    case (res_q.nof)
                        NOF_NONE: begin
                            out_data <= fix_out;
                            out_nof  <= ST_CLEAN;
                        end
                        NOF_ONE: begin
                            out_data <= fix_out;
                            out_nof  <= ST_CORR;
                        end
                        // multi-bit errors cannot be fixed: return the raw word
                        default: begin
                            out_data <= word_q;
                            out_nof  <= ST_UNCORR;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign synd_data  = word_q;
    assign fix_data   = word_q;
    assign fix_s      = res_q.s;
    assign fix_nof    = res_q.nof;
    // reserved code 11 falls through to large: neither flag set
    assign fix_small  = (cfg_q == CW_SMALL);
    assign fix_medium = (cfg_q == CW_MEDIUM);

`ifdef ECC_STATS_EN
    logic out_hs;
    assign out_hs = out_valid && out_ready;

    ecc_stat_cnt #(.W(CNT_WIDTH)) u_cnt_corr (
        .clk (clk), .rst (rst), .clr (stat_clr),
        .inc (out_hs && (out_nof == ST_CORR)),   .cnt (cnt_corr)
    );
    ecc_stat_cnt #(.W(CNT_WIDTH)) u_cnt_uncorr (
        .clk (clk), .rst (rst), .clr (stat_clr),
        .inc (out_hs && (out_nof == ST_UNCORR)), .cnt (cnt_uncorr)
    );
    ecc_stat_cnt #(.W(CNT_WIDTH)) u_cnt_tmo (
        .clk (clk), .rst (rst), .clr (stat_clr),
        .inc (out_hs && (out_nof == ST_TMO)),    .cnt (cnt_tmo)
    );
`endif

endmodule
